rtc_bus_ctrl: RTL and testbench

// - Bus cycle engine between the write/read data mux and the external RTC's multiplexed address/data bus.
// - Each request runs two phases on AD[7:0]:
//   - an address phase;
//   - a data phase, either write or read.
// - Generates the bus strobes: CS#, RD#, WR# and A/D select.
// - Read data is returned in rd_data for the mux's RTC_out input.

---
 rtl/rtc_bus_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: two-phase (address, then data) cycle engine for an external RTC on a multiplexed AD bus.
// Optional macro RTC_RDSYNC_EN: 2-flop synchronizer on ad_in and a read strobe stretched by two cycles.
module rtc_bus_ctrl #(
  parameter int T_PHASE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_wr,
  input  logic       start_rd,
  input  logic [7:0] addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       ad_sel,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done
);

`ifdef RTC_RDSYNC_EN
  localparam int RD_STB_LEN = T_PHASE + 2;
  localparam int CNT_W      = $clog2(T_PHASE + 3);
`else
  localparam int RD_STB_LEN = T_PHASE;
  localparam int CNT_W      = $clog2(T_PHASE + 1);
`endif

  localparam logic [CNT_W-1:0] PH_LOAD     = CNT_W'(T_PHASE - 1);
  localparam logic [CNT_W-1:0] RD_STB_LOAD = CNT_W'(RD_STB_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_A_SU  = 3'd1,
    S_A_STB = 3'd2,
    S_A_HLD = 3'd3,
    S_D_SU  = 3'd4,
    S_D_STB = 3'd5,
    S_D_HLD = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             is_rd_q, is_rd_d;

  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d;
  logic       ad_sel_q, ad_sel_d;
  logic       cs_n_q, cs_n_d;
  logic       wr_n_q, wr_n_d;
  logic       rd_n_q, rd_n_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       phase_end_s;
  logic [7:0] rd_sample_s;

  function automatic state_t next_phase(input state_t s);
    case (s)
      S_A_SU:  next_phase = S_A_STB;
      S_A_STB: next_phase = S_A_HLD;
      S_A_HLD: next_phase = S_D_SU;
      S_D_SU:  next_phase = S_D_STB;
      S_D_STB: next_phase = S_D_HLD;
      S_D_HLD: next_phase = S_DONE;
      default: next_phase = S_IDLE;
    endcase
  endfunction

`ifdef RTC_RDSYNC_EN
  logic [7:0] sync1_q, sync2_q;

  // Two-flop synchronizer for the pad read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= ad_in;
      sync2_q <= sync1_q;
    end
  end

  assign rd_sample_s = sync2_q;
`else
  assign rd_sample_s = ad_in;
`endif

  assign phase_end_s = (cnt_q == '0);

  // Next-state, phase counter and request latching.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    is_rd_d = is_rd_q;
    case (state_q)
      S_IDLE: begin
        if (start_wr || start_rd) begin
          state_d = S_A_SU;
          cnt_d   = PH_LOAD;
          addr_d  = addr;
          data_d  = wr_data;
          is_rd_d = ~start_wr;
        end else begin
          cnt_d = '0;
        end
      end
      S_A_SU, S_A_STB, S_A_HLD, S_D_SU, S_D_STB, S_D_HLD: begin
        if (phase_end_s) begin
          state_d = next_phase(state_q);
          if ((state_d == S_D_STB) && is_rd_q) begin
            cnt_d = RD_STB_LOAD;
          end else begin
            cnt_d = PH_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so every output comes straight from a flop.
  always_comb begin
    ad_out_d = 8'h00;
    ad_oe_d  = 1'b0;
    ad_sel_d = 1'b0;
    cs_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    case (state_d)
      S_A_SU, S_A_STB, S_A_HLD: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
        wr_n_d   = (state_d != S_A_STB);
      end
      S_D_SU, S_D_STB, S_D_HLD: begin
        cs_n_d   = 1'b0;
        ad_sel_d = 1'b1;
        if (is_rd_d) begin
          rd_n_d = (state_d != S_D_STB);
        end else begin
          ad_oe_d  = 1'b1;
          ad_out_d = data_d;
          wr_n_d   = (state_d != S_D_STB);
        end
      end
      default: begin
        ad_out_d = 8'h00;
      end
    endcase
  end

  // Read data is taken on the edge that ends the read strobe.
  always_comb begin
    if ((state_q == S_D_STB) && phase_end_s && is_rd_q) begin
      rd_data_d = rd_sample_s;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      is_rd_q   <= 1'b0;
      ad_out_q  <= 8'h00;
      ad_oe_q   <= 1'b0;
      ad_sel_q  <= 1'b0;
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      rd_data_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      is_rd_q   <= is_rd_d;
      ad_out_q  <= ad_out_d;
      ad_oe_q   <= ad_oe_d;
      ad_sel_q  <= ad_sel_d;
      cs_n_q    <= cs_n_d;
      wr_n_q    <= wr_n_d;
      rd_n_q    <= rd_n_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ad_out  = ad_out_q;
  assign ad_oe   = ad_oe_q;
  assign ad_sel  = ad_sel_q;
  assign cs_n    = cs_n_q;
  assign wr_n    = wr_n_q;
  assign rd_n    = rd_n_q;
  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: directed timing checks plus randomized traffic compared every cycle
// against a cycle-indexed behavioural model of one bus transaction.
module tb_rtc_bus_ctrl;
  localparam int T = 4;
`ifdef RTC_RDSYNC_EN
  localparam int RX = 2;
`else
  localparam int RX = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, start_wr, start_rd;
  logic [7:0] addr, wr_data, ad_in;
  logic [7:0] ad_out, rd_data;
  logic       ad_oe, ad_sel, cs_n, wr_n, rd_n, busy, done;

  always #5 clk = ~clk;

  rtc_bus_ctrl #(.T_PHASE(T)) dut (
    .clk(clk), .rst_n(rst_n), .start_wr(start_wr), .start_rd(start_rd),
    .addr(addr), .wr_data(wr_data), .ad_in(ad_in), .ad_out(ad_out),
    .ad_oe(ad_oe), .ad_sel(ad_sel), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
    .rd_data(rd_data), .busy(busy), .done(done)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0] ad_out;
    logic ad_oe, ad_sel, cs_n, wr_n, rd_n, busy, done;
  } exp_t;

  // Expected outputs in cycle k of a transaction (k=0: idle), from phase lengths.
  function automatic exp_t expect_at(input int k, input bit rd, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    int len[6];
    int ph, acc, total;
    e = '{ad_out: 8'h00, ad_oe: 1'b0, ad_sel: 1'b0, cs_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1, busy: 1'b0, done: 1'b0};
    if (k == 0) return e;
    e.busy = 1'b1;
    total = 1;
    for (int i = 0; i < 6; i++) begin
      len[i] = T;
      if (rd && i == 4) len[i] = T + RX;
      total += len[i];
    end
    if (k == total) begin
      e.done = 1'b1;
      return e;
    end
    ph = 0;
    acc = len[0];
    while (k > acc) begin
      ph++;
      acc += len[ph];
    end
    e.cs_n = 1'b0;
    e.ad_sel = (ph >= 3);
    if (ph < 3) begin
      e.ad_oe = 1'b1; e.ad_out = a; e.wr_n = (ph != 1);
    end else if (!rd) begin
      e.ad_oe = 1'b1; e.ad_out = d; e.wr_n = (ph != 4);
    end else begin
      e.rd_n = (ph != 4);
    end
    return e;
  endfunction

  // Model state: position in the current transaction and the last captured read byte.
  int         m_k = 0;
  bit         m_rd = 1'b0;
  bit         m_valid = 1'b0;
  logic [7:0] m_a = 8'h00, m_d = 8'h00, m_rdd = 8'h00;
  logic [7:0] h0 = 8'h00, h1 = 8'h00;

  initial begin : model_and_compare
    exp_t e;
    logic [7:0] smp;
    forever begin
      @(posedge clk);
      smp = (RX != 0) ? h1 : ad_in;
      if (!rst_n) begin
        m_k = 0; m_rdd = 8'h00; m_valid = 1'b1;
      end else if (m_valid) begin
        if (m_k == 0) begin
          if (start_wr || start_rd) begin
            m_k = 1; m_rd = !start_wr; m_a = addr; m_d = wr_data;
          end
        end else begin
          if (m_rd && m_k == 5*T + RX) m_rdd = smp;
          if (m_k == 6*T + 1 + (m_rd ? RX : 0)) m_k = 0;
          else m_k++;
        end
      end
      h1 = h0;
      h0 = ad_in;
      @(negedge clk);
      if (m_valid) begin
        e = expect_at(m_k, m_rd, m_a, m_d);
        chk("m_ad_out", ad_out, e.ad_out);
        chk("m_ad_oe", ad_oe, e.ad_oe);
        chk("m_ad_sel", ad_sel, e.ad_sel);
        chk("m_cs_n", cs_n, e.cs_n);
        chk("m_wr_n", wr_n, e.wr_n);
        chk("m_rd_n", rd_n, e.rd_n);
        chk("m_busy", busy, e.busy);
        chk("m_done", done, e.done);
        chk("m_rd_data", rd_data, m_rdd);
      end
    end
  end

  int cur = 0;

  // Called just after a rising edge with the DUT idle; cycle 1 begins after the accept edge.
  task automatic start_tx(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    start_wr = w; start_rd = r; addr = a; wr_data = d;
    @(posedge clk); #1;
    start_wr = 1'b0; start_rd = 1'b0;
    addr = 8'($urandom); wr_data = 8'($urandom);
    cur = 1;
  endtask

  task automatic to_cycle(input int n);
    while (cur < n) begin
      @(posedge clk); #1;
      cur++;
    end
    @(negedge clk);
  endtask

  task automatic next_edge();
    @(posedge clk); #1;
  endtask

  initial begin : stimulus
    int lows, wlows, dones;
    logic [7:0] rv;
    rst_n = 1'b0; start_wr = 1'b0; start_rd = 1'b0;
    addr = 8'h00; wr_data = 8'h00; ad_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_ad_oe", ad_oe, 1'b0);
    next_edge();
    rst_n = 1'b1;
    next_edge();

    // Write 0x59 to 0x21.
    start_tx(1'b1, 1'b0, 8'h21, 8'h59);
    to_cycle(4);  chk("wr_a_pre", wr_n, 1'b1);
    to_cycle(5);  chk("wr_a_stb5", wr_n, 1'b0); chk("wr_a_ad5", ad_out, 8'h21); chk("wr_a_sel5", ad_sel, 1'b0);
    to_cycle(8);  chk("wr_a_stb8", wr_n, 1'b0);
    to_cycle(9);  chk("wr_a_post", wr_n, 1'b1);
    to_cycle(17); chk("wr_d_stb17", wr_n, 1'b0); chk("wr_d_ad17", ad_out, 8'h59); chk("wr_d_sel17", ad_sel, 1'b1);
    to_cycle(20); chk("wr_d_stb20", wr_n, 1'b0);
    to_cycle(24); chk("wr_done24", done, 1'b0);
    to_cycle(25); chk("wr_done25", done, 1'b1);
    to_cycle(26); chk("wr_busy26", busy, 1'b0); chk("wr_done26", done, 1'b0);
    next_edge();

    // Read of 0x22 with the pad returning a known byte through the strobe.
    rv = (RX != 0) ? 8'hA5 : 8'h37;
    start_tx(1'b0, 1'b1, 8'h22, 8'h00);
    to_cycle(4*T);
    ad_in = rv;
    lows = 0;
    for (int c = 4*T + 1; c <= 5*T + RX; c++) begin
      to_cycle(c);
      if (rd_n == 1'b0) lows++;
      chk("rd_oe", ad_oe, 1'b0);
    end
    chk("rd_low_cycles", lows, T + RX);
    to_cycle(5*T + RX + 1); chk("rd_n_release", rd_n, 1'b1);
    to_cycle(6*T + 1 + RX); chk("rd_done", done, 1'b1); chk("rd_data", rd_data, rv);
    ad_in = 8'h00;
    next_edge();

    // Both starts at once: write only.
    start_tx(1'b1, 1'b1, 8'h33, 8'hC4);
    lows = 0; wlows = 0;
    for (int c = 1; c <= 26; c++) begin
      to_cycle(c);
      if (rd_n == 1'b0) lows++;
      if (wr_n == 1'b0) wlows++;
      if (c == 25) chk("both_done25", done, 1'b1);
    end
    chk("both_rd_lows", lows, 0);
    chk("both_wr_lows", wlows, 2*T);
    next_edge();

    // Read request during a write is ignored.
    start_tx(1'b1, 1'b0, 8'h44, 8'h12);
    to_cycle(10); start_rd = 1'b1;
    to_cycle(11); start_rd = 1'b0;
    dones = 0;
    for (int c = 11; c <= 30; c++) begin
      to_cycle(c);
      if (done) dones++;
      if (c == 26) chk("ign_busy26", busy, 1'b0);
    end
    chk("ign_single_done", dones, 1);
    next_edge();

    // Reset at cycle 18 during the write data strobe.
    start_tx(1'b1, 1'b0, 8'h55, 8'hAA);
    to_cycle(18); chk("rst_mid_wr_n", wr_n, 1'b0);
    rst_n = 1'b0;
    to_cycle(19);
    chk("rst_mid_cs_n", cs_n, 1'b1); chk("rst_mid_wr_n_hi", wr_n, 1'b1);
    chk("rst_mid_busy", busy, 1'b0); chk("rst_mid_rd_data", rd_data, 8'h00);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 20; c <= 30; c++) begin
      to_cycle(c);
      if (done) dones++;
    end
    chk("rst_mid_no_done", dones, 0);
    next_edge();
    start_tx(1'b1, 1'b0, 8'h66, 8'h77);
    to_cycle(25); chk("after_rst_done", done, 1'b1);
    next_edge();

    // Random traffic, including starts while busy and occasional resets.
    repeat (4000) begin
      @(posedge clk); #1;
      start_wr = ($urandom_range(0, 7) == 0);
      start_rd = ($urandom_range(0, 5) == 0);
      addr     = 8'($urandom);
      wr_data  = 8'($urandom);
      ad_in    = 8'($urandom);
      rst_n    = ($urandom_range(0, 299) != 0);
    end
    start_wr = 1'b0; start_rd = 1'b0; rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
